// File: rtl/i2c_slave_rx.sv
// I2C slave: 7-bit addressed, two-byte write into rx_data and two-byte read from tx_word.
// Optional bus-stall timeout is enabled with `define I2C_SLAVE_TIMEOUT_EN.
module i2c_slave_rx (
  input  logic        clk,
  input  logic        rst,
  input  logic        sclk,
  input  logic        sda,
  output logic        sda_oe,
  input  logic [6:0]  i_adress,
  input  logic [15:0] tx_word,
  output logic [15:0] rx_data,
  output logic        rx_valid,
  output logic        rd_done,
  output logic        nack_seen,
  output logic        busy
);
  typedef enum logic [2:0] {
    IDLE, ADDR, ACK_ADDR, WR_BYTE, ACK_WR, RD_BYTE, RD_MACK, IGNORE
  } state_t;

  state_t      state, state_next;
  logic        scl_m, scl_s, scl_d, sda_m, sda_s, sda_d;
  logic        scl_rise, scl_fall, start_det, stop_det, timeout, addr_match;
  logic [3:0]  bit_cnt, bit_cnt_next;
  logic [1:0]  byte_idx, byte_idx_next;
  logic [7:0]  shreg, shreg_next;
  logic [15:0] hold, hold_next, tx_sh, tx_sh_next, rx_data_next;
  logic        rw, rw_next, sda_oe_next, busy_next;
  logic        rx_valid_next, rd_done_next, nack_seen_next;

  // Two-flop synchronizers plus one history flop for edge detection.
  // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      {scl_m, scl_s, scl_d} <= 3'b111;
      {sda_m, sda_s, sda_d} <= 3'b111;
    end else begin
      {scl_m, scl_s, scl_d} <= {sclk, scl_m, scl_s};
      {sda_m, sda_s, sda_d} <= {sda, sda_m, sda_s};
    end
  end

  // START/STOP only need sclk high now, so a START can coincide with a sclk rise and win.
  assign scl_rise   = scl_s & ~scl_d;
  assign scl_fall   = ~scl_s & scl_d;
  assign start_det  = scl_s & sda_d & ~sda_s;
  assign stop_det   = scl_s & ~sda_d & sda_s;
  assign addr_match = (shreg[7:1] == i_adress);

`ifdef I2C_SLAVE_TIMEOUT_EN
  logic [15:0] to_cnt;
  always_ff @(posedge clk) begin
    if (rst || state == IDLE || scl_rise || scl_fall) to_cnt <= '0;
    else if (to_cnt != 16'hFFFF)                      to_cnt <= to_cnt + 16'd1;
  end
  assign timeout = (to_cnt == 16'hFFFF);
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      byte_idx  <= '0;
      shreg     <= '0;
      hold      <= '0;
      tx_sh     <= '0;
      rw        <= 1'b0;
      rx_data   <= '0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      rx_valid  <= 1'b0;
      rd_done   <= 1'b0;
      nack_seen <= 1'b0;
    end else begin
      state     <= state_next;
      bit_cnt   <= bit_cnt_next;
      byte_idx  <= byte_idx_next;
      shreg     <= shreg_next;
      hold      <= hold_next;
      tx_sh     <= tx_sh_next;
      rw        <= rw_next;
      rx_data   <= rx_data_next;
      sda_oe    <= sda_oe_next;
      busy      <= busy_next;
      rx_valid  <= rx_valid_next;
      rd_done   <= rd_done_next;
      nack_seen <= nack_seen_next;
    end
  end

  always_comb begin
    state_next = state;
    if (timeout || stop_det) state_next = IDLE;
    else if (start_det)      state_next = ADDR;
    else begin
      case (state)
        ADDR:     if (scl_fall && bit_cnt == 4'd8) state_next = addr_match ? ACK_ADDR : IGNORE;
        ACK_ADDR: if (scl_fall) state_next = rw ? RD_BYTE : WR_BYTE;
        WR_BYTE:  if (scl_fall && bit_cnt == 4'd8) state_next = (byte_idx == 2'd2) ? IGNORE : ACK_WR;
        ACK_WR:   if (scl_fall) state_next = WR_BYTE;
        RD_BYTE:  if (scl_fall && bit_cnt == 4'd8) state_next = RD_MACK;
        RD_MACK: begin
          if (scl_rise && (sda_s || byte_idx == 2'd1)) state_next = IGNORE;
          else if (scl_fall && bit_cnt == 4'd9)       state_next = RD_BYTE;
        end
        default: state_next = state;
      endcase
    end
  end

  // NOTE: every signal assigned here gets a default first, so no latches are inferred.
  always_comb begin
    bit_cnt_next   = bit_cnt;
    byte_idx_next  = byte_idx;
    shreg_next     = shreg;
    hold_next      = hold;
    tx_sh_next     = tx_sh;
    rw_next        = rw;
    rx_data_next   = rx_data;
    sda_oe_next    = sda_oe;
    busy_next      = busy;
    rx_valid_next  = 1'b0;
    rd_done_next   = 1'b0;
    nack_seen_next = 1'b0;
    if (timeout || stop_det) begin
      sda_oe_next   = 1'b0;
      busy_next     = 1'b0;
      bit_cnt_next  = '0;
      byte_idx_next = '0;
    end else if (start_det) begin
      sda_oe_next   = 1'b0;
      bit_cnt_next  = '0;
      byte_idx_next = '0;
    end else begin
      if (scl_rise && state inside {ADDR, WR_BYTE, RD_BYTE, RD_MACK}) begin
        bit_cnt_next = bit_cnt + 4'd1;
        shreg_next   = {shreg[6:0], sda_s};
      end
      case (state)
        ADDR: if (scl_fall && bit_cnt == 4'd8) begin
          bit_cnt_next = '0;
          if (addr_match) begin
            sda_oe_next = 1'b1;
            busy_next   = 1'b1;
            rw_next     = shreg[0];
          end
        end
        ACK_ADDR: if (scl_fall) begin
          bit_cnt_next  = '0;
          byte_idx_next = '0;
          if (rw) begin
            tx_sh_next  = {tx_word[14:0], 1'b0};
            sda_oe_next = ~tx_word[15];
          end else begin
            sda_oe_next = 1'b0;
          end
        end
        WR_BYTE: if (scl_fall && bit_cnt == 4'd8) begin
          bit_cnt_next = '0;
          if (byte_idx == 2'd0)      begin hold_next[15:8] = shreg; sda_oe_next = 1'b1; end
          else if (byte_idx == 2'd1) begin hold_next[7:0]  = shreg; sda_oe_next = 1'b1; end
        end
        ACK_WR: if (scl_fall) begin
          sda_oe_next   = 1'b0;
          byte_idx_next = byte_idx + 2'd1;
          if (byte_idx == 2'd1) begin
            rx_data_next  = hold;
            rx_valid_next = 1'b1;
          end
        end
        RD_BYTE: if (scl_fall) begin
          if (bit_cnt == 4'd8) sda_oe_next = 1'b0;
          else begin
            sda_oe_next = ~tx_sh[15];
            tx_sh_next  = {tx_sh[14:0], 1'b0};
          end
        end
        RD_MACK: begin
          if (scl_rise) begin
            rd_done_next   = (byte_idx == 2'd1);
            nack_seen_next = sda_s;
          end else if (scl_fall && bit_cnt == 4'd9) begin
            bit_cnt_next  = '0;
            byte_idx_next = 2'd1;
            sda_oe_next   = ~tx_sh[15];
            tx_sh_next    = {tx_sh[14:0], 1'b0};
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_slave_rx.sv
// Self-checking bench for i2c_slave_rx: a bus-level master model with an open-drain SDA,
// a table of write transactions, hand-written read/abort/restart/reset sequences, rx scoreboard.
module tb_i2c_slave_rx;
  localparam int Q = 10;  // clk cycles per quarter sclk period

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scl_m = 1'b1;
  logic        sda_m = 1'b1;
  logic        sda_bus;
  logic        sda_oe, rx_valid, rd_done, nack_seen, busy;
  logic [6:0]  own_addr = 7'h27;
  logic [15:0] tx_word = 16'h0000;
  logic [15:0] rx_data;

  assign sda_bus = sda_m & ~sda_oe;
  always #5 clk = ~clk;

  i2c_slave_rx dut (
    .clk(clk), .rst(rst), .sclk(scl_m), .sda(sda_bus), .sda_oe(sda_oe),
    .i_adress(own_addr), .tx_word(tx_word), .rx_data(rx_data), .rx_valid(rx_valid),
    .rd_done(rd_done), .nack_seen(nack_seen), .busy(busy)
  );

  int checks = 0;
  int errors = 0;
  int rxv_cyc = 0, rdd_cyc = 0, nack_cyc = 0, oe_cyc = 0;
  logic [15:0] sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Pulse monitor and rx scoreboard, sampled on the inactive clock edge.
  always @(negedge clk) begin
    if (sda_oe)    oe_cyc++;
    if (rd_done)   rdd_cyc++;
    if (nack_seen) nack_cyc++;
    if (rx_valid) begin
      rxv_cyc++;
      if (sb_q.size() == 0) check("rx_valid_unexpected", 32'(rx_valid), 32'd0);
      else                  check("rx_data_sb", 32'(rx_data), 32'(sb_q.pop_front()));
    end
  end

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic send_start();
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic send_stop();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b1; wait_q();
  endtask

  task automatic xfer_bit(input logic b, output logic r);
    sda_m = b;    wait_q();
    scl_m = 1'b1; wait_q();
    r = sda_bus;  wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) xfer_bit(d[i], r);
    xfer_bit(1'b1, r);
    ack = ~r;
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      xfer_bit(1'b1, r);
      d[i] = r;
    end
    xfer_bit(~mack, r);
  endtask

  typedef struct {
    logic [6:0]  addr;
    logic [7:0]  d0;
    logic [7:0]  d1;
    logic        exp_ack;
    logic [15:0] exp_rx;
  } wr_vec_t;

  wr_vec_t vecs[5];

  initial begin
    logic       ack;
    logic [7:0] rd;
    int rxv0, oe0, rdd0, nack0;

    vecs[0] = '{7'h27, 8'hA5, 8'h3C, 1'b1, 16'hA53C};
    vecs[1] = '{7'h26, 8'h11, 8'h22, 1'b0, 16'hA53C};
    vecs[2] = '{7'h27, 8'h12, 8'h34, 1'b1, 16'h1234};
    vecs[3] = '{7'h53, 8'h55, 8'h66, 1'b0, 16'h1234};
    vecs[4] = '{7'h27, 8'h00, 8'hFF, 1'b1, 16'h00FF};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_rx_data", 32'(rx_data), 32'h0);
    check("reset_sda_oe", 32'(sda_oe), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_pulses", 32'({rx_valid, rd_done, nack_seen}), 32'h0);
    wait_q();

    for (int v = 0; v < 5; v++) begin
      rxv0 = rxv_cyc;
      oe0  = oe_cyc;
      send_start();
      write_byte({vecs[v].addr, 1'b0}, ack);
      check($sformatf("addr_ack_v%0d", v), 32'(ack), 32'(vecs[v].exp_ack));
      check($sformatf("busy_after_addr_v%0d", v), 32'(busy), 32'(vecs[v].exp_ack));
      if (vecs[v].exp_ack) sb_q.push_back({vecs[v].d0, vecs[v].d1});
      write_byte(vecs[v].d0, ack);
      check($sformatf("d0_ack_v%0d", v), 32'(ack), 32'(vecs[v].exp_ack));
      write_byte(vecs[v].d1, ack);
      check($sformatf("d1_ack_v%0d", v), 32'(ack), 32'(vecs[v].exp_ack));
      send_stop();
      wait_q();
      check($sformatf("busy_after_stop_v%0d", v), 32'(busy), 32'h0);
      check($sformatf("rx_data_v%0d", v), 32'(rx_data), 32'(vecs[v].exp_rx));
      check($sformatf("rx_valid_count_v%0d", v), 32'(rxv_cyc - rxv0), 32'(vecs[v].exp_ack));
      if (!vecs[v].exp_ack) check($sformatf("sda_oe_idle_v%0d", v), 32'(oe_cyc - oe0), 32'h0);
    end

    // Read of 16'hBEEF: master ACKs byte 0, NACKs byte 1.
    tx_word = 16'hBEEF;
    rdd0 = rdd_cyc; nack0 = nack_cyc; rxv0 = rxv_cyc;
    send_start();
    write_byte({7'h27, 1'b1}, ack);
    check("rd_addr_ack", 32'(ack), 32'h1);
    check("rd_busy", 32'(busy), 32'h1);
    read_byte(1'b1, rd);
    check("rd_byte0", 32'(rd), 32'hBE);
    check("rd_nack_after_ack", 32'(nack_cyc - nack0), 32'h0);
    read_byte(1'b0, rd);
    check("rd_byte1", 32'(rd), 32'hEF);
    send_stop();
    wait_q();
    check("rd_done_count", 32'(rdd_cyc - rdd0), 32'h1);
    check("rd_nack_count", 32'(nack_cyc - nack0), 32'h1);
    check("rd_busy_after_stop", 32'(busy), 32'h0);
    check("rd_rx_untouched", 32'(rx_data), 32'h00FF);

    // STOP after four bits of byte 1 discards the partial write.
    rxv0 = rxv_cyc;
    send_start();
    write_byte({7'h27, 1'b0}, ack);
    write_byte(8'h77, ack);
    check("partial_b0_ack", 32'(ack), 32'h1);
    for (int i = 0; i < 4; i++) xfer_bit(i[0], ack);
    send_stop();
    wait_q();
    check("partial_rx_valid", 32'(rxv_cyc - rxv0), 32'h0);
    check("partial_rx_data", 32'(rx_data), 32'h00FF);
    check("partial_busy", 32'(busy), 32'h0);

    // Repeated START after byte 0, then a fresh two-byte write.
    rxv0 = rxv_cyc;
    send_start();
    write_byte({7'h27, 1'b0}, ack);
    write_byte(8'hAA, ack);
    send_start();
    write_byte({7'h27, 1'b0}, ack);
    check("rstart_addr_ack", 32'(ack), 32'h1);
    sb_q.push_back(16'h0102);
    write_byte(8'h01, ack);
    write_byte(8'h02, ack);
    send_stop();
    wait_q();
    check("rstart_rx_data", 32'(rx_data), 32'h0102);
    check("rstart_rx_valid", 32'(rxv_cyc - rxv0), 32'h1);

    // Third write byte is NACKed; the first two still land.
    rxv0 = rxv_cyc;
    send_start();
    write_byte({7'h27, 1'b0}, ack);
    sb_q.push_back(16'h1122);
    write_byte(8'h11, ack);
    write_byte(8'h22, ack);
    check("third_b1_ack", 32'(ack), 32'h1);
    write_byte(8'h33, ack);
    check("third_b2_nack", 32'(ack), 32'h0);
    send_stop();
    wait_q();
    check("third_rx_data", 32'(rx_data), 32'h1122);
    check("third_rx_valid", 32'(rxv_cyc - rxv0), 32'h1);

    // Reset mid-address, then a complete write.
    rxv0 = rxv_cyc; rdd0 = rdd_cyc; nack0 = nack_cyc;
    send_start();
    for (int i = 0; i < 4; i++) xfer_bit(i == 1, ack);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_rx_data", 32'(rx_data), 32'h0);
    check("midrst_busy_oe", 32'({busy, sda_oe}), 32'h0);
    send_stop();
    wait_q();
    send_start();
    write_byte({7'h27, 1'b0}, ack);
    check("postrst_addr_ack", 32'(ack), 32'h1);
    sb_q.push_back(16'hFF00);
    write_byte(8'hFF, ack);
    write_byte(8'h00, ack);
    send_stop();
    wait_q();
    check("postrst_rx_data", 32'(rx_data), 32'hFF00);
    check("postrst_rx_valid", 32'(rxv_cyc - rxv0), 32'h1);
    check("postrst_no_rd_pulses", 32'((rdd_cyc - rdd0) + (nack_cyc - nack0)), 32'h0);

    check("scoreboard_empty", 32'(sb_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end
endmodule

// File: doc/i2c_slave_rx.md
I2C_SLAVE_RX -- requirements
Module: i2c_slave_rx

Interface
REQ-001 SHALL have port clk, input, 1 bit: system clock; frequency at least 8x the sclk frequency.
REQ-002 SHALL have port rst, input, 1 bit: one clock; reset is synchronous and active-high.
REQ-003 SHALL have port sclk, input, 1 bit: I2C serial clock from the bus master; asynchronous to clk.
REQ-004 SHALL have port sda, input, 1 bit: I2C data line as sampled from the bus; asynchronous to clk.
REQ-005 SHALL have port sda_oe, output, 1 bit: 1 = pull SDA low; 0 = release the line.
REQ-006 SHALL have port i_adress, input, 7 bits: own slave address; value 7'h27 in the team bench.
REQ-007 SHALL have port tx_word, input, 16 bits: read data; bits [15:8] form byte 0 and bits [7:0] form byte 1.
REQ-008 SHALL have port rx_data, output, 16 bits: last complete write; byte 0 in [15:8], byte 1 in [7:0].
REQ-009 SHALL have port rx_valid, output, 1 bit: one-clk pulse when rx_data updates.
REQ-010 SHALL have port rd_done, output, 1 bit: one-clk pulse after the second read byte's master-ack bit.
REQ-011 SHALL have port nack_seen, output, 1 bit: one-clk pulse when the master NACKs a read byte.
REQ-012 SHALL have port busy, output, 1 bit: high from an address match until STOP or return to IDLE.

Function
REQ-013 SHALL pass sclk and sda each through a 2-flop synchronizer; edges SHALL be detected on the synchronized values (3 clk of latency from pin to event).
REQ-014 SHALL decode START as synchronized sda falling while synchronized sclk is high, and STOP as sda rising while sclk is high.
REQ-015 SHALL sample sda on detected sclk rising edges and change sda_oe only on detected sclk falling edges.
REQ-016 SHALL implement the states IDLE, ADDR, ACK_ADDR, WR_BYTE, ACK_WR, RD_BYTE, RD_MACK and IGNORE.
REQ-017 IDLE: on START go to ADDR; ignore all other bus activity.
REQ-018 ADDR: shift in 8 bits MSB first (7 address bits followed by R/W).
REQ-019 ADDR on a match: pull sda_oe=1 for the 9th bit (ACK_ADDR) and set busy.
REQ-020 ADDR on a mismatch: leave sda_oe=0 and go to IGNORE.
REQ-021 ACK_ADDR with R/W=0: release sda on the falling edge ending ACK, then go to WR_BYTE with byte index 0.
REQ-022 ACK_ADDR with R/W=1: latch tx_word, drive bit 15 on the falling edge ending ACK, then go to RD_BYTE with byte index 0.
REQ-023 WR_BYTE: shift 8 bits MSB first into a holding register, then ACK (ACK_WR).
REQ-024 After byte index 1 is ACKed: copy the holding register to rx_data and pulse rx_valid for exactly one clk, on the clk after the synchronized falling edge that ends the ACK.
REQ-025 A third or later write byte SHALL be received without ACK (NACK); the block SHALL then go to IGNORE.
REQ-026 RD_BYTE: sda_oe = ~bit for each bit, MSB first; release sda on the falling edge after the 8th bit.
REQ-027 RD_MACK: sample the master ack on the 9th rising edge.
REQ-028 RD_MACK with ack=0 on byte 0: continue with byte 1.
REQ-029 RD_MACK with ack=1: pulse nack_seen and go to IGNORE.
REQ-030 After byte 1's ack bit: pulse rd_done (regardless of ack value) and go to IGNORE.
REQ-031 IGNORE: hold sda_oe=0 until START (go to ADDR) or STOP (go to IDLE).
REQ-032 STOP in any state SHALL force IDLE, sda_oe=0 and busy=0; a partially received write SHALL be discarded (no rx_valid, rx_data unchanged).
REQ-033 A repeated START in any state SHALL go to ADDR, clear the bit and byte counters, and release sda.
REQ-034 A START and a rising sclk edge detected in the same clk: START SHALL take priority.
REQ-035 rx_data SHALL hold its value until the next completed write.

Reset
REQ-036 With rst high at a clk edge, all of the following SHALL apply: state=IDLE, sda_oe=0, rx_data=16'h0000, rx_valid=0, rd_done=0, nack_seen=0, busy=0, counters=0, synchronizers=1.
REQ-037 A reset asserted mid-transfer SHALL abort the transfer within one clk, with no pulse outputs asserted.

Configuration
REQ-038 Macro I2C_SLAVE_TIMEOUT_EN SHALL control the bus timeout feature.
REQ-039 With I2C_SLAVE_TIMEOUT_EN defined: a 16-bit counter SHALL count clk cycles while state is not IDLE and synchronized sclk is stable.
REQ-040 With I2C_SLAVE_TIMEOUT_EN defined: at 16'hFFFF the block SHALL force IDLE, sda_oe=0 and busy=0, with no pulse outputs; any sclk edge SHALL clear the counter.
REQ-041 Without I2C_SLAVE_TIMEOUT_EN: no counter logic SHALL exist, and the block SHALL wait for START/STOP indefinitely.

Verification
REQ-042 Write to address 7'h27 with bytes 8'hA5 and 8'h3C, then STOP -> ACK on bits 9, 18 and 27; rx_data=16'hA53C; exactly one rx_valid pulse; busy low after STOP.
REQ-043 Read from address 7'h27 with tx_word=16'hBEEF, master ACKs byte 0 and NACKs byte 1 -> SDA carries BE then EF; one rd_done pulse; nack_seen pulses once.
REQ-044 Address 7'h26, write of 8'h11 -> sda_oe=0 throughout; no rx_valid; busy stays 0.
REQ-045 Write of 8'h77, then STOP after 4 bits of byte 1 -> no rx_valid; rx_data unchanged; state IDLE.
REQ-046 Repeated START after byte 0, then a new write of 8'h01 and 8'h02 -> rx_data=16'h0102 with a single rx_valid pulse.
REQ-047 rst asserted mid-address, then a full write of 8'hFF and 8'h00 -> the aborted transfer is ignored; rx_data=16'hFF00.
REQ-048 With I2C_SLAVE_TIMEOUT_EN defined: sclk frozen high after the address ACK -> state returns to IDLE after 65535 clk.
